// File: rtl/ifm_read_ctrl.sv
// IFM read sequencer: walks a row-major tile, strobes the 4-deep shift
// buffer and tags every complete 1x4 window with its row/column.
module ifm_read_ctrl #(
   parameter int IFM_W  = 8,
   parameter int IFM_H  = 8,
   parameter int ADDR_W = 12,
   parameter int COL_W  = 8,
   parameter int ROW_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              stall,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              ifm_read,
   output logic              window_valid,
   output logic [COL_W-1:0]  win_col,
   output logic [ROW_W-1:0]  win_row,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [COL_W-1:0] C_LAST = COL_W'(IFM_W - 1);
   localparam logic [ROW_W-1:0] R_LAST = ROW_W'(IFM_H - 1);
   localparam logic [COL_W-1:0] C_WIN  = COL_W'(3);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_k;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic              r_rd1;
   logic [COL_W-1:0]  r_col1;
   logic [ROW_W-1:0]  r_row1;
   logic              r_last1;
   logic              r_wv;
   logic [COL_W-1:0]  r_wcol;
   logic [ROW_W-1:0]  r_wrow;
   logic              r_done;

   logic w_issue;
   logic w_last_px;
   logic w_win;

   assign w_issue   = (r_state == S_RUN) && !stall;
   assign w_last_px = (r_col == C_LAST) && (r_row == R_LAST);
   assign w_win     = r_rd1 && (r_col1 >= C_WIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_base  <= '0;
         r_k     <= '0;
         r_col   <= '0;
         r_row   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base  <= base_addr;
                  r_k     <= '0;
                  r_col   <= '0;
                  r_row   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_issue) begin
                  r_k <= r_k + 1'b1;
                  if (r_col == C_LAST) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
                  if (w_last_px) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_done) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read-return stage, then window stage one cycle behind it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd1   <= 1'b0;
         r_col1  <= '0;
         r_row1  <= '0;
         r_last1 <= 1'b0;
         r_wv    <= 1'b0;
         r_wcol  <= '0;
         r_wrow  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_rd1   <= w_issue;
         r_col1  <= r_col;
         r_row1  <= r_row;
         r_last1 <= w_issue && w_last_px;
         r_wv    <= w_win;
         r_done  <= r_last1;
         if (w_win) begin
            r_wcol <= r_col1 - C_WIN;
            r_wrow <= r_row1;
         end
      end
   end

   assign mem_rd_en    = w_issue;
   assign mem_addr     = r_base + r_k;
   assign ifm_read     = r_rd1;
   assign window_valid = r_wv;
   assign win_col      = r_wcol;
   assign win_row      = r_wrow;
   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;

endmodule

// File: tb/tb_ifm_read_ctrl.sv
// Directed bench for ifm_read_ctrl: 6x2 tile (dut_a) and 4x3 wrapping
// tile (dut_b), with hand-computed cycle-by-cycle expectations.
module tb_ifm_read_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start_a, stall_a;
   logic [11:0] base_a;
   logic        rd_a, ifm_a, wv_a, busy_a, done_a;
   logic [11:0] addr_a;
   logic [7:0]  col_a, row_a;
   logic        start_b, stall_b;
   logic [11:0] base_b;
   logic        rd_b, ifm_b, wv_b, busy_b, done_b;
   logic [11:0] addr_b;
   logic [7:0]  col_b, row_b;

   int n_chk;
   int n_fail;

   ifm_read_ctrl #(.IFM_W(6), .IFM_H(2), .ADDR_W(12), .COL_W(8), .ROW_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a),
      .stall(stall_a), .mem_rd_en(rd_a), .mem_addr(addr_a),
      .ifm_read(ifm_a), .window_valid(wv_a), .win_col(col_a),
      .win_row(row_a), .busy(busy_a), .done(done_a)
   );

   ifm_read_ctrl #(.IFM_W(4), .IFM_H(3), .ADDR_W(12), .COL_W(8), .ROW_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b),
      .stall(stall_b), .mem_rd_en(rd_b), .mem_addr(addr_b),
      .ifm_read(ifm_b), .window_valid(wv_b), .win_col(col_b),
      .win_row(row_b), .busy(busy_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      #1;
      n_chk++;
      if ({rd_a, ifm_a, wv_a, busy_a, done_a, addr_a, col_a, row_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_a got rd=%b ifm=%b wv=%b busy=%b done=%b addr=%h col=%0d row=%0d exp all 0",
                  rd_a, ifm_a, wv_a, busy_a, done_a, addr_a, col_a, row_a);
      end
      n_chk++;
      if ({rd_b, ifm_b, wv_b, busy_b, done_b, addr_b} !== '0) begin
         n_fail++;
         $display("FAIL reset_b got rd=%b busy=%b done=%b addr=%h exp all 0",
                  rd_b, busy_b, done_b, addr_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int wc[6] = '{6, 7, 8, 12, 13, 14};
      int wr[6] = '{0, 0, 0, 1, 1, 1};
      int wl[6] = '{0, 1, 2, 0, 1, 2};
      int j;
      logic e_rd, e_ifm, e_wv;
      @(negedge clk);
      base_a = 12'h010;
      start_a = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         #1;
         e_rd = (c >= 1 && c <= 12);
         e_ifm = (c >= 2 && c <= 13);
         j = -1;
         for (int i = 0; i < 6; i++) if (wc[i] == c) j = i;
         e_wv = (j >= 0);
         n_chk++;
         if ({rd_a, ifm_a, wv_a, done_a, busy_a} !== {e_rd, e_ifm, e_wv, c == 14, c <= 14}) begin
            n_fail++;
            $display("FAIL basic_ctl c=%0d got rd/ifm/wv/done/busy=%b%b%b%b%b exp %b%b%b%b%b",
                     c, rd_a, ifm_a, wv_a, done_a, busy_a, e_rd, e_ifm, e_wv, c == 14, c <= 14);
         end
         if (e_rd) begin
            n_chk++;
            if (addr_a !== 12'(12'h010 + c - 1)) begin
               n_fail++;
               $display("FAIL basic_addr c=%0d got %h exp %h", c, addr_a, 12'(12'h010 + c - 1));
            end
         end
         if (e_wv) begin
            n_chk++;
            if (row_a !== 8'(wr[j]) || col_a !== 8'(wl[j])) begin
               n_fail++;
               $display("FAIL basic_tag c=%0d got (%0d,%0d) exp (%0d,%0d)",
                        c, row_a, col_a, wr[j], wl[j]);
            end
         end
      end
   endtask

   task automatic test_stall();
      int wc[6] = '{9, 10, 11, 15, 16, 17};
      int wr[6] = '{0, 0, 0, 1, 1, 1};
      int wl[6] = '{0, 1, 2, 0, 1, 2};
      int j;
      int nwv;
      logic e_rd, e_ifm, e_wv;
      nwv = 0;
      @(negedge clk);
      base_a = 12'h010;
      start_a = 1'b1;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         stall_a = (c >= 3 && c <= 5);
         #1;
         e_rd = (c == 1 || c == 2 || (c >= 6 && c <= 15));
         e_ifm = (c == 2 || c == 3 || (c >= 7 && c <= 16));
         j = -1;
         for (int i = 0; i < 6; i++) if (wc[i] == c) j = i;
         e_wv = (j >= 0);
         if (wv_a) nwv++;
         n_chk++;
         if ({rd_a, ifm_a, wv_a, done_a, busy_a} !== {e_rd, e_ifm, e_wv, c == 17, c <= 17}) begin
            n_fail++;
            $display("FAIL stall_ctl c=%0d got rd/ifm/wv/done/busy=%b%b%b%b%b exp %b%b%b%b%b",
                     c, rd_a, ifm_a, wv_a, done_a, busy_a, e_rd, e_ifm, e_wv, c == 17, c <= 17);
         end
         if (e_rd) begin
            n_chk++;
            if (addr_a !== 12'(12'h010 + (c <= 2 ? c - 1 : c - 4))) begin
               n_fail++;
               $display("FAIL stall_addr c=%0d got %h exp %h",
                        c, addr_a, 12'(12'h010 + (c <= 2 ? c - 1 : c - 4)));
            end
         end
         if (e_wv) begin
            n_chk++;
            if (row_a !== 8'(wr[j]) || col_a !== 8'(wl[j])) begin
               n_fail++;
               $display("FAIL stall_tag c=%0d got (%0d,%0d) exp (%0d,%0d)",
                        c, row_a, col_a, wr[j], wl[j]);
            end
         end
      end
      stall_a = 1'b0;
      n_chk++;
      if (nwv != 6) begin
         n_fail++;
         $display("FAIL stall_wv_count got %0d exp 6", nwv);
      end
   endtask

   task automatic test_back_to_back();
      int nwv;
      int done_at;
      logic e_rd;
      nwv = 0;
      @(negedge clk);
      base_a = 12'h010;
      start_a = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start_a = (c == 5 || c == 14 || c == 15);
         base_a = (c == 15) ? 12'h100 : 12'h200;
         #1;
         e_rd = (c <= 12 || c == 16);
         if (wv_a) nwv++;
         n_chk++;
         if ({rd_a, done_a, busy_a} !== {e_rd, c == 14, c <= 14 || c == 16}) begin
            n_fail++;
            $display("FAIL b2b_ctl c=%0d got rd/done/busy=%b%b%b exp %b%b%b",
                     c, rd_a, done_a, busy_a, e_rd, c == 14, c <= 14 || c == 16);
         end
         if (e_rd) begin
            n_chk++;
            if (addr_a !== ((c == 16) ? 12'h100 : 12'(12'h010 + c - 1))) begin
               n_fail++;
               $display("FAIL b2b_addr c=%0d got %h exp %h",
                        c, addr_a, (c == 16) ? 12'h100 : 12'(12'h010 + c - 1));
            end
         end
      end
      start_a = 1'b0;
      n_chk++;
      if (nwv != 6) begin
         n_fail++;
         $display("FAIL b2b_wv_count got %0d exp 6", nwv);
      end
      nwv = 0;
      done_at = -1;
      for (int i = 1; i <= 20 && done_at < 0; i++) begin
         @(negedge clk);
         #1;
         if (wv_a) nwv++;
         if (done_a) done_at = i;
      end
      n_chk++;
      if (done_at != 13 || nwv != 6) begin
         n_fail++;
         $display("FAIL b2b_second_tile got done_at=%0d wv=%0d exp done_at=13 wv=6", done_at, nwv);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int nwv;
      int ndone;
      @(negedge clk);
      base_a = 12'h040;
      start_a = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start_a = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({rd_a, ifm_a, wv_a, busy_a, done_a, addr_a, col_a, row_a} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid got rd=%b ifm=%b wv=%b busy=%b done=%b addr=%h col=%0d row=%0d exp all 0",
                  rd_a, ifm_a, wv_a, busy_a, done_a, addr_a, col_a, row_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (done_a || busy_a) ndone++;
      end
      n_chk++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL rst_no_done got %0d active cycles exp 0", ndone);
      end
      nwv = 0;
      ndone = 0;
      @(negedge clk);
      base_a = 12'h040;
      start_a = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         #1;
         if (wv_a) nwv++;
         if (done_a) ndone++;
         if (c == 1) begin
            n_chk++;
            if (rd_a !== 1'b1 || addr_a !== 12'h040) begin
               n_fail++;
               $display("FAIL rst_restart_addr got rd=%b addr=%h exp rd=1 addr=040", rd_a, addr_a);
            end
         end
         if (c == 14) begin
            n_chk++;
            if (done_a !== 1'b1) begin
               n_fail++;
               $display("FAIL rst_restart_done got %b exp 1", done_a);
            end
         end
      end
      n_chk++;
      if (nwv != 6 || ndone != 1) begin
         n_fail++;
         $display("FAIL rst_restart_counts got wv=%0d done=%0d exp wv=6 done=1", nwv, ndone);
      end
   endtask

   task automatic test_wrap();
      logic [11:0] ea[12] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003,
                              12'h004, 12'h005, 12'h006, 12'h007, 12'h008, 12'h009};
      int nwv;
      logic e_wv;
      nwv = 0;
      @(negedge clk);
      base_b = 12'hFFE;
      start_b = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start_b = 1'b0;
         #1;
         e_wv = (c == 6 || c == 10 || c == 14);
         if (wv_b) nwv++;
         n_chk++;
         if ({rd_b, wv_b, done_b} !== {c <= 12, e_wv, c == 14}) begin
            n_fail++;
            $display("FAIL wrap_ctl c=%0d got rd/wv/done=%b%b%b exp %b%b%b",
                     c, rd_b, wv_b, done_b, c <= 12, e_wv, c == 14);
         end
         if (c <= 12) begin
            n_chk++;
            if (addr_b !== ea[c-1]) begin
               n_fail++;
               $display("FAIL wrap_addr c=%0d got %h exp %h", c, addr_b, ea[c-1]);
            end
         end
         if (e_wv) begin
            n_chk++;
            if (col_b !== 8'd0 || row_b !== 8'((c - 6) / 4)) begin
               n_fail++;
               $display("FAIL wrap_tag c=%0d got (%0d,%0d) exp (%0d,0)",
                        c, row_b, col_b, (c - 6) / 4);
            end
         end
      end
      n_chk++;
      if (nwv != 3) begin
         n_fail++;
         $display("FAIL wrap_wv_count got %0d exp 3", nwv);
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b1;
      start_a = 1'b0;
      stall_a = 1'b0;
      base_a = '0;
      start_b = 1'b0;
      stall_b = 1'b0;
      base_b = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      repeat (2) @(negedge clk);
      test_stall();
      repeat (2) @(negedge clk);
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      test_wrap();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
